// File: rtl/plic_target_arb_if.sv
// Bundle of the gateway, register-interface and target-facing signals of the
// multi-target PLIC arbiter; master drives requests, slave is the arbiter.
interface plic_target_arb_if #(
    parameter int SOURCES       = 8,
    parameter int TARGETS       = 2,
    parameter int PRIORITIES    = 7,
    parameter int SOURCES_BITS  = $clog2(SOURCES + 1),
    parameter int PRIORITY_BITS = $clog2(PRIORITIES + 1)
);
    logic [SOURCES-1:0]               pending_i;
    logic [SOURCES*PRIORITY_BITS-1:0] priority_i;
    logic [TARGETS*SOURCES-1:0]       enable_i;
    logic [TARGETS*PRIORITY_BITS-1:0] threshold_i;
    logic [TARGETS-1:0]               claim_i;
    logic [TARGETS-1:0]               complete_i;
    logic [TARGETS*SOURCES_BITS-1:0]  complete_id_i;
    logic [TARGETS-1:0]               ireq_o;
    logic [TARGETS*SOURCES_BITS-1:0]  id_o;
    logic [TARGETS-1:0]               claim_valid_o;
    logic [TARGETS*SOURCES_BITS-1:0]  claim_id_o;
    logic [SOURCES-1:0]               gw_claim_o;
    logic [SOURCES-1:0]               inservice_o;

    modport master (
        output pending_i, priority_i, enable_i, threshold_i,
        output claim_i, complete_i, complete_id_i,
        input  ireq_o, id_o, claim_valid_o, claim_id_o, gw_claim_o, inservice_o
    );

    modport slave (
        input  pending_i, priority_i, enable_i, threshold_i,
        input  claim_i, complete_i, complete_id_i,
        output ireq_o, id_o, claim_valid_o, claim_id_o, gw_claim_o, inservice_o
    );
endinterface

// File: rtl/plic_target_arb.sv
// Multi-target PLIC arbiter: per-target registered max-priority selection,
// threshold-gated request, and claim/complete tracking of in-service sources.
module plic_target_arb #(
    parameter int SOURCES    = 8,
    parameter int TARGETS    = 2,
    parameter int PRIORITIES = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    plic_target_arb_if.slave bus
);
    localparam int SOURCES_BITS  = $clog2(SOURCES + 1);
    localparam int PRIORITY_BITS = $clog2(PRIORITIES + 1);

    logic [SOURCES-1:0][PRIORITY_BITS-1:0] prio;
    logic [TARGETS-1:0][SOURCES-1:0]       enable;
    logic [TARGETS-1:0][PRIORITY_BITS-1:0] threshold;
    logic [TARGETS-1:0][SOURCES_BITS-1:0]  complete_id;

    assign prio        = bus.priority_i;
    assign enable      = bus.enable_i;
    assign threshold   = bus.threshold_i;
    assign complete_id = bus.complete_id_i;

    logic [SOURCES-1:0]                    inservice_q, inservice_d;
    logic [TARGETS-1:0][SOURCES_BITS-1:0]  id_q, id_d;
    logic [TARGETS-1:0][PRIORITY_BITS-1:0] best_pr_q, best_pr_d;
    logic [TARGETS-1:0]                    ireq_q, ireq_d;
    logic [TARGETS-1:0]                    claim_valid_q, claim_valid_d;
    logic [TARGETS-1:0][SOURCES_BITS-1:0]  claim_id_q, claim_id_d;
    logic [SOURCES-1:0]                    gw_claim_q, gw_claim_d;

    logic [SOURCES-1:0] set_mask;
    logic [SOURCES-1:0] clr_mask;

    // Strict '>' against a zero start both rejects priority 0 and keeps the
    // lowest index on a tie.
    always_comb begin
        id_d      = '0;
        best_pr_d = '0;
        ireq_d    = '0;
        for (int t = 0; t < TARGETS; t++) begin
            for (int s = 0; s < SOURCES; s++) begin
                if (bus.pending_i[s] && enable[t][s] && !inservice_q[s] &&
                    (prio[s] > best_pr_d[t])) begin
                    best_pr_d[t] = prio[s];
                    id_d[t]      = SOURCES_BITS'(s + 1);
                end
            end
            ireq_d[t] = best_pr_d[t] > threshold[t];
        end
    end

    // Lower-indexed targets claim first; set_mask doubles as the "already
    // granted this cycle" record. Completes only clear bits already in service,
    // so set and clear never touch the same bit.
    always_comb begin
        set_mask      = '0;
        clr_mask      = '0;
        claim_valid_d = bus.claim_i;
        claim_id_d    = claim_id_q;
        for (int t = 0; t < TARGETS; t++) begin
            if (bus.claim_i[t]) begin
                claim_id_d[t] = '0;
                for (int s = 0; s < SOURCES; s++) begin
                    if (ireq_q[t] && (best_pr_q[t] != '0) &&
                        (id_q[t] == SOURCES_BITS'(s + 1)) &&
                        !inservice_q[s] && !set_mask[s]) begin
                        set_mask[s]   = 1'b1;
                        claim_id_d[t] = id_q[t];
                    end
                end
            end
        end
        for (int t = 0; t < TARGETS; t++) begin
            if (bus.complete_i[t]) begin
                for (int s = 0; s < SOURCES; s++) begin
                    if ((complete_id[t] == SOURCES_BITS'(s + 1)) && inservice_q[s]) begin
                        clr_mask[s] = 1'b1;
                    end
                end
            end
        end
        inservice_d = (inservice_q & ~clr_mask) | set_mask;
        gw_claim_d  = set_mask;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inservice_q   <= '0;
            id_q          <= '0;
            best_pr_q     <= '0;
            ireq_q        <= '0;
            claim_valid_q <= '0;
            claim_id_q    <= '0;
            gw_claim_q    <= '0;
        end else begin
            inservice_q   <= inservice_d;
            id_q          <= id_d;
            best_pr_q     <= best_pr_d;
            ireq_q        <= ireq_d;
            claim_valid_q <= claim_valid_d;
            claim_id_q    <= claim_id_d;
            gw_claim_q    <= gw_claim_d;
        end
    end

    assign bus.ireq_o        = ireq_q;
    assign bus.id_o          = id_q;
    assign bus.claim_valid_o = claim_valid_q;
    assign bus.claim_id_o    = claim_id_q;
    assign bus.gw_claim_o    = gw_claim_q;
    assign bus.inservice_o   = inservice_q;
endmodule

// File: tb/tb_plic_target_arb.sv
// Directed plus randomized bench for plic_target_arb against a
// cycle-level behavioural model of selection and claim/complete.
module tb_plic_target_arb;
    localparam int NS = 8;
    localparam int NT = 2;
    localparam int SB = 4;
    localparam int PB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    plic_target_arb_if #(.SOURCES(NS), .TARGETS(NT), .PRIORITIES(7)) bus ();

    plic_target_arb #(.SOURCES(NS), .TARGETS(NT), .PRIORITIES(7)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    logic [NS-1:0]         pend   = '0;
    logic [NS-1:0][PB-1:0] prio   = '0;
    logic [NT-1:0][NS-1:0] en     = '0;
    logic [NT-1:0][PB-1:0] thr    = '0;
    logic [NT-1:0]         clm    = '0;
    logic [NT-1:0]         cmp    = '0;
    logic [NT-1:0][SB-1:0] cmp_id = '0;

    assign bus.pending_i     = pend;
    assign bus.priority_i    = prio;
    assign bus.enable_i      = en;
    assign bus.threshold_i   = thr;
    assign bus.claim_i       = clm;
    assign bus.complete_i    = cmp;
    assign bus.complete_id_i = cmp_id;

    // Reference model state
    bit [NS-1:0] m_ins;
    bit [NS-1:0] m_gw;
    int          m_id  [NT];
    int          m_pr  [NT];
    bit          m_ireq[NT];
    bit          m_cv  [NT];
    int          m_cid [NT];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit [NS-1:0] granted;
        bit [NS-1:0] cleared;
        int          nid[NT];
        int          npr[NT];
        int          ncid[NT];
        if (rst) begin
            m_ins = '0;
            m_gw  = '0;
            for (int t = 0; t < NT; t++) begin
                m_id[t] = 0; m_pr[t] = 0; m_ireq[t] = 0; m_cv[t] = 0; m_cid[t] = 0;
            end
            return;
        end
        granted = '0;
        cleared = '0;
        for (int t = 0; t < NT; t++) begin
            ncid[t] = m_cid[t];
            if (clm[t]) begin
                ncid[t] = 0;
                if (m_ireq[t] && m_id[t] != 0 && !m_ins[m_id[t]-1] && !granted[m_id[t]-1]) begin
                    granted[m_id[t]-1] = 1'b1;
                    ncid[t] = m_id[t];
                end
            end
            if (cmp[t]) begin
                int c;
                c = int'(cmp_id[t]);
                if (c >= 1 && c <= NS && m_ins[c-1]) cleared[c-1] = 1'b1;
            end
        end
        // Selection: find the highest eligible priority, then the first source holding it.
        for (int t = 0; t < NT; t++) begin
            int maxp;
            maxp = 0;
            for (int s = 0; s < NS; s++)
                if (pend[s] && en[t][s] && !m_ins[s] && int'(prio[s]) > maxp) maxp = int'(prio[s]);
            nid[t] = 0;
            if (maxp > 0) begin
                for (int s = NS - 1; s >= 0; s--)
                    if (pend[s] && en[t][s] && !m_ins[s] && int'(prio[s]) == maxp) nid[t] = s + 1;
            end
            npr[t] = maxp;
        end
        for (int t = 0; t < NT; t++) begin
            m_ireq[t] = npr[t] > int'(thr[t]);
            m_id[t]   = nid[t];
            m_pr[t]   = npr[t];
            m_cv[t]   = clm[t];
            m_cid[t]  = ncid[t];
        end
        m_gw  = granted;
        m_ins = (m_ins & ~cleared) | granted;
    endtask

    task automatic compare_all();
        for (int t = 0; t < NT; t++) begin
            check($sformatf("ireq[%0d]", t), 32'(bus.ireq_o[t]), 32'(m_ireq[t]));
            check($sformatf("id[%0d]", t), 32'(bus.id_o[t*SB +: SB]), 32'(m_id[t]));
            check($sformatf("claim_valid[%0d]", t), 32'(bus.claim_valid_o[t]), 32'(m_cv[t]));
            check($sformatf("claim_id[%0d]", t), 32'(bus.claim_id_o[t*SB +: SB]), 32'(m_cid[t]));
        end
        check("gw_claim", 32'(bus.gw_claim_o), 32'(m_gw));
        check("inservice", 32'(bus.inservice_o), 32'(m_ins));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    function automatic logic [SB-1:0] id_of(input int t);
        return bus.id_o[t*SB +: SB];
    endfunction

    function automatic logic [SB-1:0] cid_of(input int t);
        return bus.claim_id_o[t*SB +: SB];
    endfunction

    initial begin
        // Reset, then idle with every source pending at priority 0
        rst = 1'b1;
        pend = 8'hFF;
        en[0] = 8'hFF;
        en[1] = 8'h00;
        step();
        step();
        check("rst_ireq", 32'(bus.ireq_o), 32'h0);
        check("rst_id", 32'(bus.id_o), 32'h0);
        rst = 1'b0;
        step();
        step();
        check("idle_ireq", 32'(bus.ireq_o), 32'h0);
        check("idle_id", 32'(bus.id_o), 32'h0);

        // Priority and tie: IDs 3 and 5 at 6, others at 2
        for (int s = 0; s < NS; s++) prio[s] = 3'd2;
        prio[2] = 3'd6;
        prio[4] = 3'd6;
        thr[0] = 3'd1;
        step();
        check("tie_id0", 32'(id_of(0)), 32'd3);
        check("tie_ireq0", 32'(bus.ireq_o[0]), 32'd1);
        thr[0] = 3'd6;
        step();
        check("thr_eq_ireq0", 32'(bus.ireq_o[0]), 32'd0);
        check("thr_eq_id0", 32'(id_of(0)), 32'd3);
        thr[0] = 3'd1;
        step();

        // Claim then complete
        clm[0] = 1'b1;
        step();
        clm[0] = 1'b0;
        check("claim_id0", 32'(cid_of(0)), 32'd3);
        check("claim_gw", 32'(bus.gw_claim_o), 32'h04);
        check("claim_ins", 32'(bus.inservice_o[2]), 32'd1);
        step();
        check("after_claim_id0", 32'(id_of(0)), 32'd5);
        check("gw_pulse_end", 32'(bus.gw_claim_o), 32'h0);
        cmp[0] = 1'b1;
        cmp_id[0] = 4'd3;
        step();
        cmp[0] = 1'b0;
        check("complete_ins", 32'(bus.inservice_o[2]), 32'd0);
        step();
        check("reselect_id0", 32'(id_of(0)), 32'd3);

        // Back-to-back claims: second sees stale id with bit already set
        clm[0] = 1'b1;
        step();
        check("b2b_first", 32'(cid_of(0)), 32'd3);
        step();
        clm[0] = 1'b0;
        check("b2b_second", 32'(cid_of(0)), 32'd0);
        check("b2b_valid", 32'(bus.claim_valid_o[0]), 32'd1);

        // Invalid completes leave inservice untouched
        cmp[0] = 1'b1;
        cmp_id[0] = 4'd0;
        step();
        cmp_id[0] = 4'd9;
        step();
        cmp[0] = 1'b0;
        check("bad_complete_ins", 32'(bus.inservice_o), 32'h04);
        cmp[0] = 1'b1;
        cmp_id[0] = 4'd3;
        step();
        cmp[0] = 1'b0;
        step();

        // Claim while ireq is low
        thr[0] = 3'd7;
        step();
        clm[0] = 1'b1;
        step();
        clm[0] = 1'b0;
        check("noireq_claim_id", 32'(cid_of(0)), 32'd0);
        check("noireq_claim_valid", 32'(bus.claim_valid_o[0]), 32'd1);

        // Contention on source 4
        en[0] = 8'h08;
        en[1] = 8'h08;
        thr[0] = 3'd1;
        thr[1] = 3'd1;
        step();
        step();
        clm = 2'b11;
        step();
        clm = 2'b00;
        check("cont_t0", 32'(cid_of(0)), 32'd4);
        check("cont_t1", 32'(cid_of(1)), 32'd0);
        check("cont_valid", 32'(bus.claim_valid_o), 32'h3);

        // Reset together with a claim while a source is in service
        en[0] = 8'hFF;
        step();
        step();
        rst = 1'b1;
        clm[0] = 1'b1;
        step();
        rst = 1'b0;
        clm[0] = 1'b0;
        check("rstmid_valid", 32'(bus.claim_valid_o), 32'h0);
        check("rstmid_ins", 32'(bus.inservice_o), 32'h0);
        check("rstmid_id", 32'(bus.id_o), 32'h0);
        check("rstmid_cid", 32'(bus.claim_id_o), 32'h0);
        check("rstmid_ireq", 32'(bus.ireq_o), 32'h0);

        // Randomized phase against the model
        for (int i = 0; i < 400; i++) begin
            pend = NS'($urandom);
            for (int s = 0; s < NS; s++) prio[s] = PB'($urandom_range(0, 7));
            for (int t = 0; t < NT; t++) begin
                en[t]     = NS'($urandom) | NS'($urandom);
                thr[t]    = PB'($urandom_range(0, 3));
                clm[t]    = ($urandom_range(0, 2) == 0);
                cmp[t]    = ($urandom_range(0, 2) == 0);
                cmp_id[t] = SB'($urandom_range(0, 10));
            end
            rst = ($urandom_range(0, 60) == 0);
            step();
        end
        rst = 1'b0;
        clm = '0;
        cmp = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/plic_target_arb.md
# plic_target_arb

Multi-target PLIC arbitration and claim/complete engine. It supersedes the single-target ireq/id generator with one instance serving TARGETS contexts in parallel. It owns the per-source in-service state, so it sits between the source gateways (pending, priority) and the register interface (enable, threshold, claim/complete). Each target gets a registered highest-priority selection, a threshold-gated interrupt request and a claim/complete handshake that keeps a claimed source hidden until it is completed.

## Interface
- SOURCES, 8: number of interrupt sources; source IDs are 1..SOURCES, and 0 means "none".
- TARGETS, 2: number of targets (contexts).
- PRIORITIES, 7: highest priority level. Priority 0 means "never interrupt".
- SOURCES_BITS, $clog2(SOURCES+1): width of an ID.
- PRIORITY_BITS, $clog2(PRIORITIES+1): width of a priority or threshold.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- pending_i  in  SOURCES  level pending from the gateways; bit s is source ID s+1.
- priority_i  in  SOURCES*PRIORITY_BITS  per-source priority; slice s is source s+1.
- enable_i  in  TARGETS*SOURCES  per-target enable mask; slice t is target t.
- threshold_i  in  TARGETS*PRIORITY_BITS  per-target threshold.
- claim_i  in  TARGETS  one-cycle claim strobe per target.
- complete_i  in  TARGETS  one-cycle complete strobe per target.
- complete_id_i  in  TARGETS*SOURCES_BITS  ID being completed, qualified by complete_i.
- ireq_o  out  TARGETS  interrupt request (EIP), registered.
- id_o  out  TARGETS*SOURCES_BITS  highest-priority eligible ID, registered; 0 when none is eligible.
- claim_valid_o  out  TARGETS  one-cycle pulse, cycle after claim_i.
- claim_id_o  out  TARGETS*SOURCES_BITS  claimed ID, valid with claim_valid_o; 0 means nothing was granted.
- gw_claim_o  out  SOURCES  one-cycle pulse to the gateway of each newly claimed source.
- inservice_o  out  SOURCES  per-source in-service state.

## Operation
- **Eligibility.** For target t, source s is eligible when all of these hold:
  - pending_i[s] is 1;
  - enable_i[t][s] is 1;
  - inservice[s] is 0;
  - priority_i[s] is not 0.
- **Selection.**
  - The winner is the eligible source with the maximum priority.
  - On a priority tie, the lowest source index wins.
  - The selector runs combinationally; the result is registered into id_o[t] and an internal best_pr[t].
  - If no source is eligible, id = 0 and pr = 0.
- **Request.** ireq_o[t] is set to (pr > threshold_i[t]) and registered on the same edge as id_o. Equal priority does not interrupt.
- **Claim grant.** For target t, claim_i[t] in cycle N is granted when all of these hold:
  - ireq_o[t] is 1;
  - id_o[t] is not 0;
  - inservice[id_o[t]-1] is 0;
  - no lower-indexed target is granted the same ID in cycle N.
- **Claim result.**
  - Granted: claim_id_o[t] = id_o[t] at N+1; inservice bit set at N+1; gw_claim_o bit pulses at N+1.
  - Not granted: claim_id_o[t] = 0 with claim_valid_o[t] = 1 at N+1.
- **Complete.**
  - complete_i[t] with complete_id_i in 1..SOURCES clears the matching inservice bit at the next edge.
  - ID 0, an ID greater than SOURCES, or an ID that is not in service is ignored with no error.
  - Multiple targets completing the same ID in one cycle is equivalent to a single completion.
- **Same source claimed and completed in one cycle.** The claim is refused (the bit is still set) and the complete clears the bit. Claim and complete can never both act on one bit in the same cycle.
- **Masking.** No enable check is applied on complete; masking is software's job.

## Timing
- Reset (rst_i high at an edge) clears all of the following, with no claim or complete taking effect in that cycle:
  - ireq_o, id_o, claim_valid_o, claim_id_o, gw_claim_o: all 0.
  - inservice: all 0.
  - best_pr: 0.
- Input (pending, priority, enable, threshold, inservice) to ireq_o/id_o latency: 1 cycle.
- Claim at N:
  - claim_valid_o/claim_id_o/gw_claim_o/inservice_o update at N+1.
  - ireq_o/id_o reflect the removal of the claimed source at N+2.
  - A back-to-back claim at N+1 sees the stale id_o but inservice is already set, so it returns 0.
- Complete at N: the inservice bit clears at N+1, and the source is reselectable on ireq_o/id_o at N+2.
- claim_valid_o and gw_claim_o are single-cycle pulses. claim_id_o holds its value until the next claim or reset.
- No throughput limit: one claim and one complete per target per cycle.

## Test plan
- Reset, then idle:
  - Stimulus: pending=0xFF, all priorities 0.
  - Required: ireq_o=0 and id_o=0 for every target.
- Priority and tie:
  - Stimulus: target 0 enabled for all sources; priorities of sources 3 and 5 = 6, all others = 2; threshold=1.
  - Required: id_o[0]=3 and ireq_o[0]=1 exactly one cycle after inputs settle.
  - Follow-on: threshold=6 gives ireq_o[0]=0 while id_o[0] stays 3.
- Claim/complete:
  - Claim at N: claim_id=3 at N+1, gw_claim_o[2] pulses, inservice_o[2]=1.
  - At N+2: id_o[0]=5.
  - Complete ID 3: inservice_o[2]=0 one cycle later, and id_o[0]=3 again one cycle after that.
- Contention:
  - Stimulus: both targets enabled only for source 4; both claim in the same cycle.
  - Required: target 0 gets 4 and target 1 gets 0; both claim_valid_o pulse.
- Back-to-back and invalid:
  - A claim at N+1 after a grant at N returns 0.
  - Complete of ID 0 or 9 (SOURCES=8) leaves inservice unchanged.
  - Claim while ireq_o=0 returns 0.
- Reset mid-operation:
  - Stimulus: rst_i asserted in the same cycle as claim_i, with inservice nonzero.
  - Required: next cycle has claim_valid_o=0, inservice_o=0, and every output 0.
